seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_hex_decode.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side signal bundle of seg_scan_ctrl; master drives control, slave is the controller.
interface seg_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  digit_mask;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_done;
  logic        pending;

  modport master (
    output en, load, load_val, digit_mask,
    input  seg, an, upd_done, pending
  );

  modport slave (
    input  en, load, load_val, digit_mask,
    output seg, an, upd_done, pending
  );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin 4-digit seven-segment scanner with frame-aligned value updates.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DIV_W    = 17
)(
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(TICK_DIV - 1);

  scan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             upd_q, upd_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             tick, frame;
  logic [3:0]       nib;
  logic [6:0]       dec_seg;
  logic [3:0]       mask_eff;

  assign nib = active_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  // A digit stays lit once it or any more-significant nibble is non-zero.
  logic [3:0] lit;
  always_comb begin
    lit[3] = |active_q[15:12];
    lit[2] = lit[3] | (|active_q[11:8]);
    lit[1] = lit[2] | (|active_q[7:4]);
    lit[0] = 1'b1;
  end
  assign mask_eff = bus.digit_mask & lit;
`else
  assign mask_eff = bus.digit_mask;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (bus.en)  state_d = SCAN;
      SCAN:    if (!bus.en) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Output logic; registered below so seg/an lag the index by one cycle.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (state_d == SCAN) begin
      seg_d = dec_seg;
      if (mask_eff[idx_q]) an_d = ~(4'b0001 << idx_q);
    end
  end

  // Prescaler, index and load handshake
  always_comb begin
    tick      = bus.en && (cnt_q == CNT_LAST);
    frame     = tick && (idx_q == 2'd3);
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    upd_d     = 1'b0;
    if (bus.en) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    if (tick)   idx_d = idx_q + 2'd1;
    if (bus.load) begin
      shadow_d = bus.load_val;
      if (frame) begin
        active_d  = bus.load_val;
        pending_d = 1'b0;
        upd_d     = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
      upd_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      upd_q     <= 1'b0;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      upd_q     <= upd_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.upd_done = upd_q;
  assign bus.pending  = pending_q;

endmodule
